gshare_predictor: RTL
=====================

# gshare_predictor

Parametrised successor to the two-bit predictor in the front end. It predicts conditional branches at IF time from a PC-indexed, global-history-hashed table of saturating counters. It keeps an in-order FIFO of in-flight predictions, trains the table at ROB commit, and on a mispredict drives one flush pulse plus a redirect address to IF, LSB, ROB, RS, register file and CDB.

## Interface
- BHT_INDEX_BITS, 6: table has 2^BHT_INDEX_BITS counters.
- CNT_BITS, 2: width of each saturating counter (>=2).
- HIST_BITS, 4: global history length (<= BHT_INDEX_BITS).
- FIFO_LOG, 2: in-flight FIFO depth = 2^FIFO_LOG.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when 0, all state holds
- ask  in  1  IF requests a prediction this cycle
- ask_pc  in  32  branch PC
- ask_jump_addr  in  32  taken target
- ask_next_addr  in  32  fall-through address
- pred_valid  out  1  prediction returned
- pred_jump  out  1  predicted taken
- full  out  1  FIFO holds 2^FIFO_LOG entries
- commit  in  1  oldest branch committed
- commit_jump  in  1  actual outcome of that branch
- flush  out  1  one-cycle flush to all consumers
- redirect_addr  out  32  correct PC, valid while flush=1

## Operation
- Index = ask_pc[BHT_INDEX_BITS+1:2] XOR zero-extended spec_hist. Predict taken iff counter MSB = 1.
- On an accepted ask:
  - push {index, pred, jump_addr, next_addr} at tail;
  - spec_hist <= {spec_hist[HIST_BITS-2:0], pred};
  - pred_valid <= 1, pred_jump <= pred.
- When there is no accepted ask, pred_valid <= 0.
- An ask while full is ignored: no push, pred_valid=0. IF must not do this; the predictor tolerates it.
- On commit with a non-empty FIFO:
  - pop head;
  - update counter[head.index]: +1 saturating at 2^CNT_BITS-1 if commit_jump, else -1 saturating at 0;
  - commit_hist <= {commit_hist[HIST_BITS-2:0], commit_jump}.
- Commit with an empty FIFO is ignored.
- Mispredict (commit_jump != head.pred):
  - flush <= 1;
  - redirect_addr <= commit_jump ? head.jump_addr : head.next_addr;
  - FIFO cleared (head=tail=count=0);
  - spec_hist <= updated commit_hist.
- Same-cycle ask and commit:
  - If the commit is correct, both apply; count stays unchanged; the prediction uses the counter value before this cycle's update.
  - If the commit mispredicts, the ask is discarded (no push, pred_valid=0).
- Flush cycle: while flush=1, ask and commit are ignored. flush returns to 0 the next cycle.
- Pointer wrap: head/tail are FIFO_LOG bits wide and wrap naturally. count is FIFO_LOG+1 bits; full = (count == 2^FIFO_LOG).

## Timing
- Reset values:
  - pred_valid=0, pred_jump=0, flush=0, redirect_addr=0, full=0;
  - head=tail=count=0, spec_hist=commit_hist=0;
  - all counters = 2^(CNT_BITS-1)-1 (weakly not-taken).
- rst wins over everything, including an in-progress flush.
- pred_valid/pred_jump are registered, 1 cycle after ask.
- flush/redirect_addr are registered, 1 cycle after the mispredicting commit, and high for exactly one cycle.
- full is combinational from count and reflects pushes/pops of the previous edge.
- rdy=0 freezes all registers, outputs included.

## Test plan
- Reset, then ask pc=0x100 → next cycle pred_valid=1, pred_jump=0, full=0. Then commit_jump=0 → no flush, count=0.
- Ask pc=0x100, then commit_jump=1 (jump_addr=0x200) → next cycle flush=1 and redirect_addr=0x200; following cycle flush=0, count=0, spec_hist=4'b0001.
- Training: repeat ask pc=0x40 + taken commit. Five taken commits saturate history to 4'b1111 and raise counter[0x1F] to 2 → 6th ask returns pred_jump=1; taken commit causes no flush.
- Four asks with no commit → full=1. 5th ask → pred_valid=0, count stays 4. Then one correct commit → full=0.
- Same-cycle ask and mispredicting commit → flush=1 next cycle, pred_valid=0, FIFO empty. Same-cycle ask and correct commit → pred_valid=1, count unchanged.
- Assert rst during the flush cycle → flush=0 and all reset values next cycle. Hold rdy=0 over an ask → no pred_valid until rdy=1.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare branch predictor.
// Predicts at IF time from a table of saturating counters. The table index is
// the PC hashed with the speculative global history. Predictions in flight are
// kept in an in-order FIFO. The table is trained at commit, and a mispredicted
// commit produces a one-cycle flush together with the corrected fetch address.
module gshare_predictor #(
  parameter int BHT_INDEX_BITS = 6,
  parameter int CNT_BITS       = 2,
  parameter int HIST_BITS      = 4,
  parameter int FIFO_LOG       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ask,
  input  logic [31:0] ask_pc,
  input  logic [31:0] ask_jump_addr,
  input  logic [31:0] ask_next_addr,
  output logic        pred_valid,
  output logic        pred_jump,
  output logic        full,
  input  logic        commit,
  input  logic        commit_jump,
  output logic        flush,
  output logic [31:0] redirect_addr
);

  localparam int BHT_SIZE = 1 << BHT_INDEX_BITS;
  localparam int DEPTH    = 1 << FIFO_LOG;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [FIFO_LOG:0]   COUNT_FULL = (FIFO_LOG+1)'(DEPTH);

  // Counter table and in-flight prediction FIFO
  logic [CNT_BITS-1:0]       bht [BHT_SIZE];
  logic [BHT_INDEX_BITS-1:0] fifo_idx  [DEPTH];
  logic                      fifo_pred [DEPTH];
  logic [31:0]               fifo_jump [DEPTH];
  logic [31:0]               fifo_next [DEPTH];

  logic [FIFO_LOG-1:0] head;
  logic [FIFO_LOG-1:0] tail;
  logic [FIFO_LOG:0]   count;
  logic [HIST_BITS-1:0] spec_hist;
  logic [HIST_BITS-1:0] commit_hist;

  // Decoded per-cycle events
  logic [BHT_INDEX_BITS-1:0] hist_ext;
  logic [BHT_INDEX_BITS-1:0] ask_idx;
  logic                      ask_pred;
  logic [BHT_INDEX_BITS-1:0] head_idx;
  logic                      head_pred;
  logic [CNT_BITS-1:0]       cnt_cur;
  logic [CNT_BITS-1:0]       cnt_upd;
  logic                      accept_commit;
  logic                      mispredict;
  logic                      accept_ask;
  logic [FIFO_LOG:0]         count_nxt;
  logic [HIST_BITS-1:0]      spec_hist_shift;
  logic [HIST_BITS-1:0]      commit_hist_nxt;

  assign full = (count == COUNT_FULL);

  // Zero-extend the history so it can be XORed into the PC index bits
  always_comb begin
    hist_ext = '0;
    hist_ext[HIST_BITS-1:0] = spec_hist;
  end

  assign ask_idx   = ask_pc[BHT_INDEX_BITS+1:2] ^ hist_ext;
  assign ask_pred  = bht[ask_idx][CNT_BITS-1];
  assign head_idx  = fifo_idx[head];
  assign head_pred = fifo_pred[head];
  assign cnt_cur   = bht[head_idx];

  assign spec_hist_shift = {spec_hist[HIST_BITS-2:0], ask_pred};
  assign commit_hist_nxt = {commit_hist[HIST_BITS-2:0], commit_jump};

  // Nothing is accepted during the flush cycle. A mispredicting commit
  // discards any same-cycle ask because that ask was fetched down the wrong path.
  assign accept_commit = rdy & ~flush & commit & (count != '0);
  assign mispredict    = accept_commit & (commit_jump != head_pred);
  assign accept_ask    = rdy & ~flush & ask & ~full & ~mispredict;

  // Saturating counter training value for the committing entry
  always_comb begin
    cnt_upd = cnt_cur;
    if (commit_jump) begin
      if (cnt_cur != CNT_MAX) cnt_upd = cnt_cur + CNT_BITS'(1);
    end else begin
      if (cnt_cur != '0) cnt_upd = cnt_cur - CNT_BITS'(1);
    end
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    if (mispredict) begin
      count_nxt = '0;
    end else begin
      case ({accept_ask, accept_commit})
        2'b10:   count_nxt = count + (FIFO_LOG+1)'(1);
        2'b01:   count_nxt = count - (FIFO_LOG+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Counter table: weakly not-taken at reset, trained on every accepted commit.
  // A read for a same-cycle ask sees the value from before this update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) bht[i] <= CNT_INIT;
    end else if (accept_commit) begin
      bht[head_idx] <= cnt_upd;
    end
  end

  // FIFO payload; its validity is tracked by the pointers alone, so no reset is needed
  always_ff @(posedge clk) begin
    if (!rst && accept_ask) begin
      fifo_idx[tail]  <= ask_idx;
      fifo_pred[tail] <= ask_pred;
      fifo_jump[tail] <= ask_jump_addr;
      fifo_next[tail] <= ask_next_addr;
    end
  end

  // FIFO pointers and occupancy; head and tail wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (mispredict) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (accept_ask)    tail <= tail + FIFO_LOG'(1);
        if (accept_commit) head <= head + FIFO_LOG'(1);
      end
      count <= count_nxt;
    end
  end

  // Global histories: speculative for lookup, committed for recovery on a mispredict
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_hist   <= '0;
      commit_hist <= '0;
    end else if (rdy) begin
      if (accept_commit) commit_hist <= commit_hist_nxt;
      if (mispredict)      spec_hist <= commit_hist_nxt;
      else if (accept_ask) spec_hist <= spec_hist_shift;
    end
  end

  // Registered prediction response
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid <= 1'b0;
      pred_jump  <= 1'b0;
    end else if (rdy) begin
      pred_valid <= accept_ask;
      if (accept_ask) pred_jump <= ask_pred;
    end
  end

  // One-cycle flush pulse with the corrected fetch address
  always_ff @(posedge clk) begin
    if (rst) begin
      flush         <= 1'b0;
      redirect_addr <= '0;
    end else if (rdy) begin
      flush <= mispredict;
      if (mispredict) redirect_addr <= commit_jump ? fifo_jump[head] : fifo_next[head];
    end
  end

endmodule
